// File: rtl/master_slave_pkg.sv
// master_slave_pkg: {s,r} command encoding and master next-state decode.
// MASTER_SLAVE_TOGGLE_EN selects JK toggle for s=r=1 instead of hold.
package master_slave_pkg;
    typedef enum logic [1:0] {HOLD = 2'b00, CLR = 2'b01, SET = 2'b10, BOTH = 2'b11} cmd_e;
`ifdef MASTER_SLAVE_TOGGLE_EN
    localparam bit TOGGLE_EN = 1'b1;
`else
    localparam bit TOGGLE_EN = 1'b0;
`endif
    function automatic logic next_master(input cmd_e cmd, input logic m, input logic q);
        return cmd == CLR ? 1'b0 : cmd == SET ? 1'b1 : (cmd == BOTH && TOGGLE_EN) ? ~q : m;
    endfunction
endpackage

// File: rtl/master_slave_ff_stage.sv
// ms_stage: one-bit master/slave SR (or JK with MASTER_SLAVE_TOGGLE_EN) stage.
module ms_stage import master_slave_pkg::*; #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic master_q,
    output logic qn,
    output logic illegal
);
    logic slave, rst_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            master_q <= RST_VAL;
            rst_q    <= 1'b1;
        end else begin
            master_q <= next_master(cmd_e'({s, r}), master_q, qn);
            rst_q    <= 1'b0;
        end
    end
    always_ff @(negedge clk)
        slave <= master_q;
    // Reset must reach qn at the rising edge, before the slave next copies the master.
    assign qn = rst_q ? RST_VAL : slave;
`ifdef MASTER_SLAVE_TOGGLE_EN
    assign illegal = 1'b0;
`else
    always_ff @(posedge clk)
        illegal <= rst ? 1'b0 : s & r;
`endif
endmodule

// File: rtl/master_slave_ff.sv
// master_slave_ff: WIDTH independent master/slave flip-flops.
// MASTER_SLAVE_TOGGLE_EN: s=r=1 toggles (JK); otherwise holds and flags illegal.
module master_slave_ff #(
    parameter int WIDTH = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] qn_bar,
    output logic [WIDTH-1:0] master_q,
    output logic [WIDTH-1:0] illegal
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ms_stage #(.RST_VAL(RESET_VAL[i])) u_stage (
            .clk(clk),
            .rst(rst),
            .s(s[i]),
            .r(r[i]),
            .master_q(master_q[i]),
            .qn(qn[i]),
            .illegal(illegal[i])
        );
    end
    assign qn_bar = ~qn;
endmodule

// File: tb/tb_master_slave_ff.sv
// tb_master_slave_ff: scoreboard bench for master_slave_ff (WIDTH=4).
module tb_master_slave_ff;
    localparam int W = 4;
`ifdef MASTER_SLAVE_TOGGLE_EN
    localparam logic TOG = 1'b1;
`else
    localparam logic TOG = 1'b0;
`endif
    typedef struct {
        logic [W-1:0] m;
        logic [W-1:0] ill;
        logic [W-1:0] qr;
        logic [W-1:0] qf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [W-1:0] s = '0, r = '0;
    logic [W-1:0] qn, qn_bar, master_q, illegal;
    logic [W-1:0] mm, mq;
    bit started = 1'b0;
    int checks = 0, errors = 0;
    exp_t sb[$];

    master_slave_ff #(.WIDTH(W), .RESET_VAL('0)) dut (
        .clk(clk), .rst(rst), .s(s), .r(r),
        .qn(qn), .qn_bar(qn_bar), .master_q(master_q), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%b exp=%b", tag, $time, got, exp);
        end
    endtask

    task automatic step(input logic rs, input logic [W-1:0] sv, input logic [W-1:0] rv);
        exp_t e;
        logic [W-1:0] nm;
        s = sv;
        r = rv;
        #1 rst = rs;
        #1;
        if (started) chk("qn_no_async", qn, mq);
        nm = (sv & ~rv) | (~sv & ~rv & mm) | (sv & rv & (TOG ? ~mq : mm));
        e.m   = rs ? '0 : nm;
        e.ill = rs ? '0 : sv & rv & {W{~TOG}};
        e.qr  = rs ? '0 : mq;
        e.qf  = e.m;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("master_q", master_q, e.m);
        chk("illegal", illegal, e.ill);
        chk("qn_rise", qn, e.qr);
        chk("qn_bar_rise", qn_bar, ~e.qr);
        s = W'($urandom);
        r = W'($urandom);
        @(negedge clk);
        #1;
        chk("qn_fall", qn, e.qf);
        chk("qn_bar_fall", qn_bar, ~e.qf);
        mm = e.m;
        mq = e.qf;
        started = 1'b1;
    endtask

    initial begin
        step(1'b1, 4'h0, 4'h0);
        step(1'b0, 4'h0, 4'h0);
        step(1'b0, 4'h0, 4'hF);
        step(1'b0, 4'hF, 4'h0);
        step(1'b0, 4'hF, 4'hF);
        step(1'b0, 4'hF, 4'hF);
        step(1'b0, 4'h0, 4'h0);
        step(1'b0, 4'hF, 4'h0);
        step(1'b1, 4'hF, 4'h0);
        step(1'b0, 4'h0, 4'h0);
        step(1'b0, 4'hF, 4'h0);
        step(1'b1, 4'hA, 4'h5);
        step(1'b0, 4'hA, 4'h5);
        step(1'b0, 4'h0, 4'h0);
        step(1'b0, 4'hC, 4'hA);
        step(1'b0, 4'hC, 4'hA);
        for (int k = 0; k < 40; k++)
            step($urandom_range(0, 7) == 0, W'($urandom), W'($urandom));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/master_slave_ff.md
MASTER_SLAVE_FF -- requirements
Module: master_slave_ff

Interface
REQ-001 Parameter WIDTH, default 1, number of independent flip-flop bits.
REQ-002 Parameter RESET_VAL, default all-zero, value loaded into master and slave by reset.
REQ-003 clk  input  1  single clock; master captures on rising edge, slave updates on falling edge.
REQ-004 rst  input  1  reset, synchronous, active-high, sampled on clk rising edge.
REQ-005 s  input  WIDTH  per-bit set request.
REQ-006 r  input  WIDTH  per-bit reset request.
REQ-007 qn  output  WIDTH  slave (registered) state.
REQ-008 qn_bar  output  WIDTH  bitwise complement of qn at all times.
REQ-009 master_q  output  WIDTH  master stage state, for observation.
REQ-010 illegal  output  WIDTH  per-bit flag: s=r=1 sampled at last rising edge while toggle mode is compiled out.

Function
REQ-011 Per bit on clk rising edge (rst=0), master SHALL load: s=0,r=0 -> hold master; s=0,r=1 -> 0; s=1,r=0 -> 1; s=1,r=1 -> per REQ-012/REQ-013.
REQ-012 Toggle compiled in: s=r=1 SHALL load the complement of current qn into the master (JK behaviour).
REQ-013 Toggle compiled out: s=r=1 SHALL hold the master and set the bit's illegal flag.
REQ-014 The illegal flag SHALL update on every rising edge and clear on the next rising edge with s,r not both 1.
REQ-015 On clk falling edge the slave SHALL copy the master: qn changes only at falling edges, half a cycle after the capturing rising edge.
REQ-016 s and r SHALL be sampled only at rising edges; changes between edges have no effect.
REQ-017 qn_bar SHALL be combinational ~qn; qn and qn_bar are never equal.
REQ-018 All bits operate independently; no cross-bit interaction.

Reset
REQ-019 rst=1 at a rising edge SHALL load RESET_VAL into master and slave at that same edge, clear illegal, and override s/r.
REQ-020 Reset asserted mid-cycle SHALL take effect only at the next rising edge; no asynchronous path.
REQ-021 After rst deasserts, the first rising edge with rst=0 SHALL resume normal capture.
REQ-022 Before the first reset, outputs SHALL be undefined (X in simulation).

Configuration
REQ-023 Macro MASTER_SLAVE_TOGGLE_EN: defined -> REQ-012 applies and illegal is tied to 0; undefined -> REQ-013 applies.

Structure
REQ-024 A shared package master_slave_pkg SHALL hold the command encoding (HOLD=2'b00, CLR=2'b01, SET=2'b10, BOTH=2'b11 from {s,r}) and a decode function returning next master value.
REQ-025 One sub-module ms_stage (one bit: master register, slave register, illegal flag) SHALL be instantiated WIDTH times by a generate loop.

Verification
REQ-026 Clock period 10 ns, clk=0 at t=0. Reset at rising edge t=5, then s=0,r=0 from t=10 -> qn=0, qn_bar=1 held.
REQ-027 s=0,r=1 at t=20 -> master_q=0 at rising edge t=25, qn=0 at falling edge t=30.
REQ-028 s=1,r=0 at t=30 -> master_q=1 at t=35, qn=1/qn_bar=0 at t=40, not earlier.
REQ-029 s=1,r=1 at t=40, toggle compiled in -> qn=0 at t=50, 1 at t=60 while held. Toggle compiled out -> qn stays 1, illegal=1 from t=45.
REQ-030 qn=1, rst=1 asserted at t=62 with s=1,r=0 -> master_q=qn=0 at rising edge t=65. Returns to 1 only after rst=0 and the next rising/falling edge pair.
REQ-031 WIDTH=4: s=4'b1010, r=4'b0101 from reset -> qn=4'b1010 after one full cycle. Then s=r=4'b0000 -> qn holds 4'b1010.
